lfsr_rng_scheduler: RTL
=======================

Name: lfsr_rng_scheduler

Overview:
- Owns one 8-bit many-to-one LFSR and shares its output between two requesters as a random-number server.
- Sequences the LFSR through reset, seed load and warm-up, then serves one fresh value per grant.
- Arbitrates requesters round-robin.
- Sits between the LFSR datapath and game/test logic that needs pseudo-random bytes.

Parameters:
SEED, 8'hBD, LFSR value loaded at reset; also replaces an illegal all-zero seed_data.
WARMUP, 4, LFSR steps after reset/reseed before serving; legal range 1..15.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
seed_load  in  1  one-cycle pulse: load seed_data into the LFSR and restart warm-up
seed_data  in  8  new seed, sampled when seed_load=1
req  in  2  level request per requester, req[0] and req[1]
gnt  out  2  one-hot, one-cycle grant pulse, or 0
rnd_data  out  8  value delivered with the grant
rnd_valid  out  1  high exactly when gnt != 0
rnd_id  out  1  index of the granted requester; valid with rnd_valid
busy  out  1  high while in WARM

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. All outputs are registered.
- LFSR step rule: next = {q[6:0], q[7]^q[3]^q[2]^q[1]}.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - lfsr=SEED, state=WARM, warm count=0.
  - gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, busy=1.
  - Round-robin last-granted pointer=1, so req[0] wins the first tie.
- States:
  - WARM: LFSR steps every edge and the count increments. On the edge that performs step number WARMUP, go to READY and busy→0. No grants in WARM; req is ignored.
  - READY, no eligible request: LFSR holds; gnt=0 and rnd_valid=0 next cycle.
  - READY, eligible request: the winner's gnt bit, rnd_valid, rnd_id and rnd_data=current lfsr are all registered on that edge, so they are visible the cycle after req is sampled (latency 1). The LFSR steps on the same edge, so every delivered value is consumed once. The pointer updates to the winner.
- Eligibility: req[i] high, AND requester i was not granted in the current cycle (gnt[i]=0). A held request therefore receives at most one grant every two cycles. Two alternating requesters can be granted on consecutive cycles.
- Arbitration: if both are eligible, grant the one that is not the pointer. If only one is eligible, grant it.
- seed_load in any state:
  - lfsr = (seed_data==0) ? SEED : seed_data; count=0; state=WARM; busy=1.
  - gnt and rnd_valid go to 0 on that edge; a simultaneous request is dropped, not queued.
  - Pointer unchanged.
- The LFSR can never hold 0; zero substitution guarantees this.
- rnd_data holds its last delivered value when rnd_valid=0.

Test Plan:
1. Reset sequence (SEED=BD, WARMUP=4): assert rst then release, no req -> busy=1 for exactly 4 rising edges, then busy=0 with internal lfsr=DB; gnt stays 0 throughout.
2. Single requester held: req=01 continuously after warm-up -> grants on alternate cycles, rnd_id=0, rnd_data sequence DB, B7, 6F, DF.
3. Both requesting: req=11 held -> gnt sequence 01, 10, 01, 10 on consecutive cycles, rnd_data DB, B7, 6F, DF.
4. Seed handling: seed_load with seed_data=00 while req=11 in READY -> no grant that cycle, busy=1, lfsr reloaded to BD. After 4 edges, first grant delivers DB to requester 1 (the pointer is preserved from before the reload).
5. Reset mid-grant: assert rst while gnt=10 -> gnt, rnd_valid, rnd_data and rnd_id clear asynchronously before the next edge. The post-reset sequence repeats scenario 1 exactly.

Source files
------------

// File: rtl/lfsr_rng_scheduler.sv
// Random-number server: one 8-bit LFSR shared between two requesters.
// Sequences seed load and warm-up, then hands out one fresh value per round-robin grant.
module lfsr_rng_scheduler #(
    parameter logic [7:0]  SEED   = 8'hBD,
    parameter int unsigned WARMUP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic [7:0] seed_data,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [7:0] rnd_data,
    output logic       rnd_valid,
    output logic       rnd_id,
    output logic       busy
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 8;

    typedef enum logic {
        WARM,
        READY
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   lfsr, lfsr_n, lfsr_step;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      gnt_n;
    logic [DW-1:0]   rnd_data_n;
    logic            rnd_valid_n;
    logic            rnd_id_n;
    logic            busy_n;
    logic            ptr, ptr_n;
    logic [1:0]      elig;
    logic            win;

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[3] ^ lfsr[2] ^ lfsr[1]};

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WARM;
            lfsr      <= SEED;
            cnt       <= '0;
            gnt       <= 2'b00;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
            rnd_id    <= 1'b0;
            busy      <= 1'b1;
            ptr       <= 1'b1;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            rnd_data  <= rnd_data_n;
            rnd_valid <= rnd_valid_n;
            rnd_id    <= rnd_id_n;
            busy      <= busy_n;
            ptr       <= ptr_n;
        end
    end

    // Next-state, arbitration and LFSR advance
    always_comb begin
        state_n     = state;
        lfsr_n      = lfsr;
        cnt_n       = cnt;
        gnt_n       = 2'b00;
        rnd_data_n  = rnd_data;
        rnd_valid_n = 1'b0;
        rnd_id_n    = rnd_id;
        busy_n      = busy;
        ptr_n       = ptr;
        win         = 1'b0;
        // A requester granted this cycle sits out one cycle
        elig        = req & ~gnt;

        if (seed_load) begin
            // All-zero seed would lock the LFSR, so substitute the default
            lfsr_n  = (seed_data == '0) ? SEED : seed_data;
            cnt_n   = '0;
            state_n = WARM;
            busy_n  = 1'b1;
        end else begin
            case (state)
                WARM: begin
                    lfsr_n = lfsr_step;
                    cnt_n  = cnt + CW'(1);
                    if (cnt == CW'(WARMUP - 1)) begin
                        state_n = READY;
                        busy_n  = 1'b0;
                    end
                end
                READY: begin
                    if (elig != 2'b00) begin
                        win         = (elig == 2'b11) ? ~ptr : elig[1];
                        gnt_n       = win ? 2'b10 : 2'b01;
                        rnd_valid_n = 1'b1;
                        rnd_id_n    = win;
                        rnd_data_n  = lfsr;
                        lfsr_n      = lfsr_step;
                        ptr_n       = win;
                    end
                end
                default: state_n = WARM;
            endcase
        end
    end

endmodule
